// File: rtl/mic1_sequencer.sv
// rtl/mic1_sequencer.sv - MIC-1 microsequencer: MPC/MIR, next-address logic, memory request handshakes
module mic1_sequencer #(
  parameter int               MPC_W      = 9,
  parameter int               MBR_W      = 8,
  parameter logic [MPC_W-1:0] RESET_ADDR = '0,
  parameter logic [MPC_W-1:0] HALT_ADDR  = '1
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [MPC_W-1:0]  cs_addr,
  input  logic [MPC_W+26:0] cs_rdata,
  output logic [MPC_W+26:0] mir,
  output logic              exec_en,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic [MBR_W-1:0]  mbr,
  output logic              n_flag,
  output logic              z_flag,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ack,
  output logic              fetch,
  input  logic              fetch_ack,
  output logic              halted
);

  localparam int MIR_W = MPC_W + 27;

  // MIR bit positions of the control fields the sequencer itself consumes
  localparam int MEM_FETCH = 4;
  localparam int MEM_READ  = 5;
  localparam int MEM_WRITE = 6;
  localparam int JAM_Z     = 24;
  localparam int JAM_N     = 25;
  localparam int JAM_MPC   = 26;
  localparam int NEXT_LSB  = 27;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_FETCH,
    ST_LOAD,
    ST_EXEC,
    ST_HALTED
  } state_t;

  state_t           state_q, state_d;
  logic [MPC_W-1:0] mpc_q, mpc_d;
  logic [MPC_W-1:0] next_addr;
  logic [MIR_W-1:0] mir_q, mir_d;
  logic             n_flag_q, n_flag_d;
  logic             z_flag_q, z_flag_d;
  logic             mem_rd_q, mem_rd_d;
  logic             mem_wr_q, mem_wr_d;
  logic             fetch_q, fetch_d;
  logic             pending;
  logic             exec_c;

  // Any outstanding request blocks the commit of the microinstruction sitting in EXEC.
  assign pending = mem_rd_q | mem_wr_q | fetch_q;

  // Sequencer control: FETCH -> LOAD -> EXEC, holding EXEC while a request is outstanding.
  always_comb begin
    state_d = state_q;
    exec_c  = 1'b0;
    case (state_q)
      ST_RESET:  state_d = ST_FETCH;
      ST_FETCH:  state_d = (mpc_q == HALT_ADDR) ? ST_HALTED : ST_LOAD;
      ST_LOAD:   state_d = ST_EXEC;
      ST_EXEC: begin
        if (!pending) begin
          exec_c  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RESET;
    endcase
  end

  // Next microaddress: NEXT, MSB forced by the enabled flag jumps, then OR'd with MBR for JMPC.
  always_comb begin
    next_addr = mir_q[MIR_W-1:NEXT_LSB];
    if ((mir_q[JAM_N] && alu_n) || (mir_q[JAM_Z] && alu_z)) begin
      next_addr[MPC_W-1] = 1'b1;
    end
    if (mir_q[JAM_MPC]) begin
      next_addr = next_addr | MPC_W'(mbr);
    end
  end

  // Register updates: MIR on LOAD, MPC/flags/new requests on commit, request clear on ack.
  always_comb begin
    mpc_d    = mpc_q;
    mir_d    = mir_q;
    n_flag_d = n_flag_q;
    z_flag_d = z_flag_q;
    mem_rd_d = mem_rd_q & ~mem_ack;
    mem_wr_d = mem_wr_q & ~mem_ack;
    fetch_d  = fetch_q & ~fetch_ack;
    if (state_q == ST_LOAD) begin
      mir_d = cs_rdata;
    end
    if (exec_c) begin
      // Nothing is pending on a commit cycle, so a stray ack here cannot cancel a new request.
      mpc_d    = next_addr;
      n_flag_d = alu_n;
      z_flag_d = alu_z;
      mem_rd_d = mir_q[MEM_READ];
      mem_wr_d = mir_q[MEM_WRITE];
      fetch_d  = mir_q[MEM_FETCH];
    end
  end

  // State and register bank; reset drops any outstanding request without waiting for its ack.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_RESET;
      mpc_q    <= RESET_ADDR;
      mir_q    <= '0;
      n_flag_q <= 1'b0;
      z_flag_q <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      fetch_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mpc_q    <= mpc_d;
      mir_q    <= mir_d;
      n_flag_q <= n_flag_d;
      z_flag_q <= z_flag_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      fetch_q  <= fetch_d;
    end
  end

  assign cs_addr = mpc_q;
  assign mir     = mir_q;
  assign exec_en = exec_c;
  assign n_flag  = n_flag_q;
  assign z_flag  = z_flag_q;
  assign mem_rd  = mem_rd_q;
  assign mem_wr  = mem_wr_q;
  assign fetch   = fetch_q;
  assign halted  = (state_q == ST_HALTED);

endmodule

// File: tb/tb_mic1_sequencer.sv
// tb/tb_mic1_sequencer.sv - self-checking bench for mic1_sequencer
`timescale 1ns/1ps
module tb_mic1_sequencer;

  localparam logic [2:0] J_Z  = 3'b001;
  localparam logic [2:0] J_N  = 3'b010;
  localparam logic [2:0] J_MP = 3'b100;
  localparam logic [2:0] M_F  = 3'b001;
  localparam logic [2:0] M_RD = 3'b010;
  localparam logic [2:0] M_WR = 3'b100;

  logic        clk = 1'b0;
  logic        resetn;
  logic [8:0]  cs_addr;
  logic [35:0] cs_rdata;
  logic [35:0] mir;
  logic        exec_en;
  logic        alu_n, alu_z;
  logic [7:0]  mbr;
  logic        n_flag, z_flag;
  logic        mem_rd, mem_wr, mem_ack;
  logic        fetch, fetch_ack;
  logic        halted;

  int checks = 0;
  int failures = 0;

  logic [35:0] rom [0:511];
  int          mem_delay, fetch_delay;
  bit          rand_alu, spurious, use_dir;
  logic [7:0]  mbr_dir, mbr_on_ack, mbr_latched;

  always #5 clk = ~clk;

  mic1_sequencer dut (
    .clk(clk), .resetn(resetn), .cs_addr(cs_addr), .cs_rdata(cs_rdata), .mir(mir),
    .exec_en(exec_en), .alu_n(alu_n), .alu_z(alu_z), .mbr(mbr), .n_flag(n_flag),
    .z_flag(z_flag), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack),
    .fetch(fetch), .fetch_ack(fetch_ack), .halted(halted)
  );

  // Synchronous control store: data for the address seen in one cycle appears in the next.
  initial begin : cs_model
    logic [8:0] prev;
    prev = '0;
    cs_rdata = '0;
    forever begin
      @(negedge clk);
      cs_rdata = rom[prev];
      prev = cs_addr;
    end
  end

  // Memory responder: ack after a programmed delay (0 = first request cycle); MBR changes on fetch ack.
  initial begin : ack_model
    int mcnt, fcnt;
    mcnt = 0; fcnt = 0;
    mem_ack = 1'b0; fetch_ack = 1'b0; mbr = '0; mbr_latched = '0;
    forever begin
      @(negedge clk);
      if (mem_rd || mem_wr) begin
        mcnt++;
        mem_ack = (mcnt == mem_delay + 1);
      end else begin
        mcnt = 0;
        mem_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (fetch) begin
        fcnt++;
        fetch_ack = (fcnt == fetch_delay + 1);
        if (fetch_ack) mbr_latched = mbr_on_ack;
      end else begin
        fcnt = 0;
        fetch_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (use_dir) mbr_latched = mbr_dir;
      mbr = mbr_latched;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  function automatic logic [35:0] mk(input logic [8:0] nxt, input logic [2:0] jam, input logic [2:0] mem);
    return {nxt, jam, 17'h0, mem, 4'h0};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) rom[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Negedges until exec_en is seen high; -1 on timeout. Optionally re-randomises ALU flags off-commit.
  task automatic wait_exec(input int limit, output int gap);
    gap = 0;
    forever begin
      @(negedge clk);
      gap++;
      if (exec_en === 1'b1) return;
      if (gap >= limit) begin
        gap = -1;
        return;
      end
      if (rand_alu) {alu_n, alu_z} = 2'($urandom);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    #3;
    resetn = 1'b0;
    #1;
    checks++;
    if (cs_addr !== 9'h000) begin failures++; $display("FAIL reset_cs_addr got=%h exp=000", cs_addr); end
    checks++;
    if (mir !== 36'h0) begin failures++; $display("FAIL reset_mir got=%h exp=0", mir); end
    checks++;
    if ({exec_en, mem_rd, mem_wr, fetch, halted, n_flag, z_flag} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000000", {exec_en, mem_rd, mem_wr, fetch, halted, n_flag, z_flag});
    end
  endtask

  task automatic test_sequence();
    logic [8:0] exp_addr [3] = '{9'h000, 9'h005, 9'h009};
    int gap;
    clear_rom();
    rom[0] = mk(9'h005, 3'b0, 3'b0);
    rom[5] = mk(9'h009, 3'b0, 3'b0);
    rom[9] = mk(9'h000, 3'b0, 3'b0);
    alu_n = 1'b0; alu_z = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wait_exec(20, gap);
      checks++;
      if (gap !== 3) begin failures++; $display("FAIL seq_gap i=%0d got=%0d exp=3", i, gap); end
      checks++;
      if (cs_addr !== exp_addr[i]) begin failures++; $display("FAIL seq_addr i=%0d got=%h exp=%h", i, cs_addr, exp_addr[i]); end
      checks++;
      if (mir !== rom[exp_addr[i]]) begin failures++; $display("FAIL seq_mir i=%0d got=%h exp=%h", i, mir, rom[exp_addr[i]]); end
      checks++;
      if ({n_flag, z_flag} !== 2'b00) begin failures++; $display("FAIL seq_flags i=%0d got=%b exp=00", i, {n_flag, z_flag}); end
    end
  endtask

  task automatic test_jam();
    logic [2:0] jam [5] = '{J_Z, J_Z, J_N, J_N, J_N | J_Z};
    logic       nv  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       zv  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [8:0] exp [5] = '{9'h110, 9'h010, 9'h110, 9'h010, 9'h110};
    int gap;
    use_dir = 1'b1; mbr_dir = 8'hFF;
    for (int t = 0; t < 5; t++) begin
      clear_rom();
      rom[0] = mk(9'h010, jam[t], 3'b0);
      alu_n = nv[t]; alu_z = zv[t];
      do_reset();
      wait_exec(20, gap);
      wait_exec(20, gap);
      checks++;
      if (gap !== 3) begin failures++; $display("FAIL jam_gap t=%0d got=%0d exp=3", t, gap); end
      checks++;
      if (cs_addr !== exp[t]) begin failures++; $display("FAIL jam_addr t=%0d got=%h exp=%h", t, cs_addr, exp[t]); end
      checks++;
      if ({n_flag, z_flag} !== {nv[t], zv[t]}) begin
        failures++; $display("FAIL jam_flags t=%0d got=%b exp=%b", t, {n_flag, z_flag}, {nv[t], zv[t]});
      end
    end
  endtask

  task automatic test_jmpc();
    logic [8:0] nxt [3] = '{9'h100, 9'h000, 9'h003};
    logic [2:0] jam [3] = '{J_MP, J_MP, J_MP | J_N};
    logic [7:0] mv  [3] = '{8'h59, 8'hFF, 8'h40};
    logic [8:0] exp [3] = '{9'h159, 9'h0FF, 9'h143};
    int gap;
    use_dir = 1'b1;
    alu_n = 1'b1; alu_z = 1'b0;
    for (int t = 0; t < 3; t++) begin
      clear_rom();
      rom[0] = mk(nxt[t], jam[t], 3'b0);
      mbr_dir = mv[t];
      do_reset();
      wait_exec(20, gap);
      wait_exec(20, gap);
      checks++;
      if (cs_addr !== exp[t]) begin failures++; $display("FAIL jmpc_addr t=%0d got=%h exp=%h", t, cs_addr, exp[t]); end
    end
  endtask

  task automatic test_read_stall();
    logic [2:0] mems [4] = '{M_RD, M_RD | M_WR, M_WR, M_RD};
    int         dl   [4] = '{4, 2, 0, 1};
    int gap, ex;
    logic er, ew;
    alu_n = 1'b0; alu_z = 1'b0;
    for (int t = 0; t < 4; t++) begin
      clear_rom();
      rom[0] = mk(9'h002, 3'b0, mems[t]);
      rom[2] = mk(9'h007, 3'b0, 3'b0);
      mem_delay = dl[t];
      do_reset();
      wait_exec(20, gap);
      checks++;
      if (gap !== 3) begin failures++; $display("FAIL rd_first_gap t=%0d got=%0d exp=3", t, gap); end
      ex = (dl[t] + 2 > 3) ? dl[t] + 2 : 3;
      for (int c = 1; c <= ex; c++) begin
        @(negedge clk);
        er = mems[t][1] && (c <= dl[t] + 1);
        ew = mems[t][2] && (c <= dl[t] + 1);
        checks++;
        if ({mem_rd, mem_wr} !== {er, ew}) begin
          failures++; $display("FAIL rd_req t=%0d c=%0d got=%b exp=%b", t, c, {mem_rd, mem_wr}, {er, ew});
        end
        checks++;
        if (exec_en !== (c == ex)) begin
          failures++; $display("FAIL rd_exec t=%0d c=%0d got=%b exp=%b", t, c, exec_en, (c == ex));
        end
        checks++;
        if (cs_addr !== 9'h002) begin failures++; $display("FAIL rd_mpc t=%0d c=%0d got=%h exp=002", t, c, cs_addr); end
      end
    end
    mem_delay = 0;
  endtask

  task automatic test_fetch_jmpc();
    int gap;
    clear_rom();
    rom[0] = mk(9'h003, 3'b0, M_F);
    rom[3] = mk(9'h100, J_MP, 3'b0);
    use_dir = 1'b1; mbr_dir = 8'hAA;
    mbr_on_ack = 8'h3C;
    fetch_delay = 3;
    do_reset();
    use_dir = 1'b0;
    wait_exec(20, gap);
    wait_exec(20, gap);
    checks++;
    if (gap !== 5) begin failures++; $display("FAIL fetch_gap got=%0d exp=5", gap); end
    checks++;
    if (mbr !== 8'h3C) begin failures++; $display("FAIL fetch_mbr got=%h exp=3c", mbr); end
    checks++;
    if (fetch !== 1'b0) begin failures++; $display("FAIL fetch_clear got=%b exp=0", fetch); end
    wait_exec(20, gap);
    checks++;
    if (cs_addr !== 9'h13C) begin failures++; $display("FAIL fetch_jmpc_addr got=%h exp=13c", cs_addr); end
    fetch_delay = 0;
  endtask

  task automatic test_halt();
    int gap;
    clear_rom();
    rom[0] = mk(9'h1FF, 3'b0, M_RD);
    mem_delay = 5;
    do_reset();
    wait_exec(20, gap);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      checks++;
      if (halted !== (c >= 2)) begin failures++; $display("FAIL halt_flag c=%0d got=%b exp=%b", c, halted, (c >= 2)); end
      checks++;
      if (mem_rd !== (c <= 6)) begin failures++; $display("FAIL halt_rd c=%0d got=%b exp=%b", c, mem_rd, (c <= 6)); end
      checks++;
      if ({exec_en, fetch, mem_wr} !== 3'b000) begin
        failures++; $display("FAIL halt_quiet c=%0d got=%b exp=000", c, {exec_en, fetch, mem_wr});
      end
    end
    checks++;
    if (cs_addr !== 9'h1FF) begin failures++; $display("FAIL halt_addr got=%h exp=1ff", cs_addr); end
    mem_delay = 0;
  endtask

  task automatic test_reset_mid_stall();
    int gap;
    clear_rom();
    rom[0] = mk(9'h004, 3'b0, M_RD);
    rom[4] = mk(9'h000, 3'b0, M_WR);
    mem_delay = 20;
    do_reset();
    wait_exec(20, gap);
    repeat (5) @(negedge clk);
    checks++;
    if ({mem_rd, exec_en, cs_addr} !== {1'b1, 1'b0, 9'h004}) begin
      failures++; $display("FAIL stall_pre got=%b/%b/%h exp=1/0/004", mem_rd, exec_en, cs_addr);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({exec_en, mem_rd, mem_wr, fetch, halted, n_flag, z_flag} !== 7'b0) begin
      failures++; $display("FAIL midrst_outputs got=%b exp=0000000", {exec_en, mem_rd, mem_wr, fetch, halted, n_flag, z_flag});
    end
    checks++;
    if ({cs_addr, mir} !== {9'h000, 36'h0}) begin failures++; $display("FAIL midrst_regs got=%h/%h exp=000/0", cs_addr, mir); end
    mem_delay = 0;
    @(negedge clk);
    resetn = 1'b1;
    wait_exec(20, gap);
    checks++;
    if (gap !== 3 || cs_addr !== 9'h000 || mir !== rom[0]) begin
      failures++; $display("FAIL midrst_restart gap=%0d addr=%h mir=%h exp=3/000/%h", gap, cs_addr, mir, rom[0]);
    end
  endtask

  task automatic test_random();
    logic [8:0]  mpc_m, nxt;
    logic [7:0]  cur_mbr;
    logic [35:0] w;
    logic        pn, pz;
    int gap, exp_gap;
    for (int i = 0; i < 512; i++) begin
      rom[i] = {9'($urandom) & 9'h17F, 3'($urandom), 17'($urandom), 3'($urandom), 4'($urandom)};
    end
    use_dir = 1'b1; mbr_dir = 8'h00;
    rand_alu = 1'b1; spurious = 1'b1;
    do_reset();
    use_dir = 1'b0;
    mpc_m = 9'h000; cur_mbr = 8'h00; pn = 1'b0; pz = 1'b0; exp_gap = 3;
    for (int k = 0; k < 150; k++) begin
      wait_exec(60, gap);
      checks++;
      if (gap !== exp_gap) begin failures++; $display("FAIL rnd_gap k=%0d got=%0d exp=%0d", k, gap, exp_gap); end
      if (gap < 0) break;
      w = rom[mpc_m];
      checks++;
      if (cs_addr !== mpc_m) begin failures++; $display("FAIL rnd_addr k=%0d got=%h exp=%h", k, cs_addr, mpc_m); end
      checks++;
      if (mir !== w) begin failures++; $display("FAIL rnd_mir k=%0d got=%h exp=%h", k, mir, w); end
      checks++;
      if ({n_flag, z_flag} !== {pn, pz}) begin failures++; $display("FAIL rnd_flags k=%0d got=%b exp=%b", k, {n_flag, z_flag}, {pn, pz}); end
      nxt = w[35:27];
      if ((w[25] && alu_n) || (w[24] && alu_z)) nxt = nxt | 9'h100;
      if (w[26]) nxt = nxt | {1'b0, cur_mbr};
      pn = alu_n; pz = alu_z;
      mem_delay = $urandom_range(0, 5);
      fetch_delay = $urandom_range(0, 5);
      mbr_on_ack = 8'($urandom) & 8'h7F;
      exp_gap = 3;
      if ((w[5] || w[6]) && mem_delay + 2 > exp_gap) exp_gap = mem_delay + 2;
      if (w[4]) begin
        if (fetch_delay + 2 > exp_gap) exp_gap = fetch_delay + 2;
        cur_mbr = mbr_on_ack;
      end
      mpc_m = nxt;
    end
    rand_alu = 1'b0; spurious = 1'b0;
  endtask

  initial begin : main
    resetn = 1'b0; alu_n = 1'b0; alu_z = 1'b0;
    rand_alu = 1'b0; spurious = 1'b0; use_dir = 1'b1;
    mbr_dir = 8'h00; mbr_on_ack = 8'h00; mem_delay = 0; fetch_delay = 0;
    clear_rom();
    test_reset();
    test_sequence();
    test_jam();
    test_jmpc();
    test_read_stall();
    test_fetch_jmpc();
    test_halt();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
